keccak_squeeze_unit: RTL and testbench

- Squeeze-side output streamer for the Keccak core.
- Captures the 1088-bit rate portion of the state and streams it as 64-bit words over a valid/ready interface, counting down the requested output length.
- When a rate block is exhausted and more output is still owed, it requests one more permutation from the datapath controller, waits for completion, then reloads.
- Sits between the state register and the host output port; it is the reading counterpart of the absorb-side input buffering.

---
 rtl/keccak_pkg.sv | 14 +
 rtl/piso_buffer.sv | 29 ++
 rtl/keccak_squeeze_unit.sv | 121 ++++++++++++
 tb/tb_keccak_squeeze_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak core constants and squeeze-side types
package keccak_pkg;

  localparam int RATE_BITS  = 1088;
  localparam int RATE_WORDS = 17;
  localparam int OUT_LEN_W  = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    PERM_WAIT = 2'd2
  } squeeze_state_t;

endpackage

// File: rtl/piso_buffer.sv
// rtl/piso_buffer.sv - parallel-in serial-out word buffer, low word first
module piso_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     shift,
  input  logic [WIDTH*DEPTH-1:0]   din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH*DEPTH-1:0] sreg;

  // load wins over shift so a reload never loses the fresh block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {{WIDTH{1'b0}}, sreg[WIDTH*DEPTH-1:WIDTH]};
    end
  end

  assign dout = sreg[WIDTH-1:0];

endmodule

// File: rtl/keccak_squeeze_unit.sv
// rtl/keccak_squeeze_unit.sv - streams rate words out, requesting permutations as needed
// Optional SQUEEZE_BYTE_MASK_EN: out_len in bytes, adds data_keep byte enables.
module keccak_squeeze_unit
  import keccak_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = RATE_WORDS,
  parameter int LEN_W = OUT_LEN_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   out_len,
  input  logic [W*DEPTH-1:0] rate_in,
  output logic               perm_req,
  input  logic               perm_done,
  output logic [W-1:0]       data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               data_last,
`ifdef SQUEEZE_BYTE_MASK_EN
  output logic [W/8-1:0]     data_keep,
`endif
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = $clog2(DEPTH);

  squeeze_state_t     state;
  logic [LEN_W-1:0]   remaining;
  logic [IDX_W-1:0]   idx;
  logic               xfer;
  logic               load;
  logic               is_last;
  logic [LEN_W-1:0]   dec;

`ifdef SQUEEZE_BYTE_MASK_EN
  localparam int BYTES = W / 8;

  assign is_last = (remaining <= LEN_W'(BYTES));
  assign dec     = is_last ? remaining : LEN_W'(BYTES);

  always_comb begin
    data_keep = '1;
    if (is_last) begin
      for (int b = 0; b < BYTES; b++) begin
        data_keep[b] = (LEN_W'(b) < remaining);
      end
    end
  end
`else
  assign is_last = (remaining == LEN_W'(1));
  assign dec     = LEN_W'(1);
`endif

  assign data_valid = (state == STREAM);
  assign perm_req   = (state == PERM_WAIT);
  assign busy       = (state != IDLE);
  assign data_last  = data_valid && is_last;
  assign xfer       = data_valid && data_ready;
  assign load       = ((state == IDLE) && start && (out_len != '0)) ||
                      ((state == PERM_WAIT) && perm_done);

  piso_buffer #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (xfer),
    .din   (rate_in),
    .dout  (data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      idx       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (out_len != '0) begin
              remaining <= out_len;
              idx       <= '0;
              state     <= STREAM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            remaining <= remaining - dec;
            idx       <= idx + IDX_W'(1);
            // finishing takes priority, so an exact multiple of the block never requests a permutation
            if (is_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (idx == IDX_W'(DEPTH - 1)) begin
              state <= PERM_WAIT;
            end
          end
        end
        PERM_WAIT: begin
          if (perm_done) begin
            idx   <= '0;
            state <= STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// tb/tb_keccak_squeeze_unit.sv - table-driven scoreboard bench for keccak_squeeze_unit
module tb_keccak_squeeze_unit;

  localparam int W     = 64;
  localparam int DEPTH = 17;
  localparam int LEN_W = 28;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [LEN_W-1:0]   out_len;
  logic [W*DEPTH-1:0] rate_in;
  logic               perm_req;
  logic               perm_done;
  logic [W-1:0]       data_out;
  logic               data_valid;
  logic               data_ready;
  logic               data_last;
  logic               busy;
  logic               done;

  keccak_squeeze_unit #(.W(W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .out_len    (out_len),
    .rate_in    (rate_in),
    .perm_req   (perm_req),
    .perm_done  (perm_done),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int          len;
    int          mode;
    logic [63:0] b0;
    logic [63:0] b1;
    int          exp_perms;
  } vec_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;
  logic        zero_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_last_xfer = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [W*DEPTH-1:0] blk(input logic [63:0] base);
    logic [W*DEPTH-1:0] r;
    for (int i = 0; i < DEPTH; i++) r[i*W +: W] = base + 64'(i);
    return r;
  endfunction

  function automatic logic ready_fn(input int mode, input int cyc);
    if (mode == 1) return (cyc % 3) == 0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  // monitor: scoreboard pops, stall stability and done timing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(data_valid), 64'd1);
        chk("stall_data", data_out, prev_data);
      end
      if (!zero_mode && (done || prev_last_xfer)) chk("done_timing", 64'(done), 64'(prev_last_xfer));
      if (done) done_cnt++;
      if (data_valid && data_ready) begin
        xfer_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got=%0h want=none", data_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word", data_out, e.data);
          chk("last", 64'(data_last), 64'(e.last));
        end
      end
      prev_stall     = data_valid && !data_ready;
      prev_data      = data_out;
      prev_last_xfer = data_valid && data_ready && data_last;
    end
  end

  task automatic push_words(input int len, input logic [63:0] b0, input logic [63:0] b1);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.data = (k < DEPTH) ? b0 + 64'(k) : b1 + 64'(k - DEPTH);
      e.last = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d0, x0, cyc, pw, perms;
    rate_in = blk(v.b0);
    push_words(v.len, v.b0, v.b1);
    d0 = done_cnt;
    x0 = xfer_cnt;
    perms = 0;
    pw = 0;
    out_len = LEN_W'(v.len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_ready = ready_fn(v.mode, 0);
    @(negedge clk);
    chk("first_valid", 64'(data_valid), 64'd1);
    cyc = 1;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk); #1;
      perm_done = 1'b0;
      data_ready = ready_fn(v.mode, cyc);
      if (perm_req) begin
        pw++;
        if (pw == 24) begin
          rate_in = blk(v.b1);
          perm_done = 1'b1;
          perms++;
          pw = 0;
        end
      end
      cyc++;
    end
    perm_done = 1'b0;
    if (cyc >= 3000) begin
      total++;
      bad++;
      $display("FAIL timeout: len=%0d got=no_done want=done", v.len);
    end
    @(posedge clk); #1;
    chk("idle_valid", 64'(data_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_perm_req", 64'(perm_req), 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("xfer_count", 64'(xfer_cnt - x0), 64'(v.len));
    chk("perm_count", 64'(perms), 64'(v.exp_perms));
    sb.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int d0, x0, cyc;
    vecs[0] = '{len: 4,  mode: 0, b0: 64'h1000, b1: 64'h0,    exp_perms: 0};
    vecs[1] = '{len: 17, mode: 0, b0: 64'h2000, b1: 64'h0,    exp_perms: 0};
    vecs[2] = '{len: 20, mode: 0, b0: 64'h1000, b1: 64'h5000, exp_perms: 1};
    vecs[3] = '{len: 5,  mode: 1, b0: 64'h3000, b1: 64'h0,    exp_perms: 0};
    vecs[4] = '{len: 34, mode: 2, b0: 64'h6000, b1: 64'h7000, exp_perms: 1};

    rst_n = 1'b0;
    start = 1'b0;
    out_len = '0;
    rate_in = '0;
    perm_done = 1'b0;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_last", 64'(data_last), 64'd0);
    chk("rst_perm_req", 64'(perm_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // zero-length request: done pulse only
    zero_mode = 1'b1;
    x0 = xfer_cnt;
    out_len = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_valid", 64'(data_valid), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("zero_done_clear", 64'(done), 64'd0);
    chk("zero_xfers", 64'(xfer_cnt - x0), 64'd0);
    zero_mode = 1'b0;

    // start while streaming must not disturb the running request
    rate_in = blk(64'hA000);
    push_words(6, 64'hA000, 64'h0);
    d0 = done_cnt;
    x0 = xfer_cnt;
    data_ready = 1'b0;
    out_len = LEN_W'(6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rate_in = blk(64'hB000);
    out_len = LEN_W'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ign", 64'(busy), 64'd1);
    data_ready = 1'b1;
    cyc = 0;
    while (done_cnt == d0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_xfers", 64'(xfer_cnt - x0), 64'd6);
    chk("ign_sb_left", 64'(sb.size()), 64'd0);
    sb.delete();

    // reset during PERM_WAIT aborts without done
    rate_in = blk(64'h8000);
    push_words(30, 64'h8000, 64'h9000);
    out_len = LEN_W'(30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!perm_req && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pw_reached", 64'(perm_req), 64'd1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_perm_req", 64'(perm_req), 64'd0);
    chk("abort_valid", 64'(data_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data_out", data_out, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_vec('{len: 2, mode: 0, b0: 64'hC000, b1: 64'h0, exp_perms: 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
